// File: rtl/ccmp_sched.sv
// CCMP engine scheduler: arbitrates TX/RX sessions onto one engine, tracks
// session completion, MIC status and an inactivity watchdog.
module ccmp_sched #(
  parameter int WDOG_W     = 10,
  parameter int WDOG_MAX   = 1000,
  parameter int STARVE_MAX = 3
) (
  input  logic       macCoreClk,
  input  logic       macCoreSRst,
  input  logic       txReq,
  input  logic       rxReq,
  input  logic       ccmpIsIdle,
  input  logic       activity_p,
  input  logic       micValid_p,
  input  logic       micPassed_p,
  input  logic       micFailed_p,
  input  logic       rxError_p,
  input  logic       tcTxErrorP,
  output logic       txGnt,
  output logic       rxGnt,
  output logic       initCCMP_p,
  output logic       txDone_p,
  output logic       rxDone_p,
  output logic       doneErr,
  output logic       rxMicOk,
  output logic       rxMicFail,
  output logic       wdogAbort_p,
  output logic [1:0] schedCS
);
  localparam int STARVE_W = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [WDOG_W-1:0]   WDOG_LIM   = WDOG_W'(WDOG_MAX);
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_INIT  = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic                  tx_gnt_q, tx_gnt_d;
  logic                  rx_gnt_q, rx_gnt_d;
  logic                  err_q, err_d;
  logic                  mic_ok_q, mic_ok_d;
  logic                  mic_fail_q, mic_fail_d;
  logic [WDOG_W-1:0]     wdog_q, wdog_d;
  logic [STARVE_W-1:0]   starve_q, starve_d;

  logic start, tx_wins, owner_err, owner_drop, wdog_expire, drain_done;

  // Request/grant handshake: txReq/rxReq are levels held by the requester for
  // the whole session; a grant is held from INIT through DRAIN and dropping
  // the owner's request while in RUN aborts the session.
  always_comb begin
    state_d    = state_q;
    tx_gnt_d   = tx_gnt_q;
    rx_gnt_d   = rx_gnt_q;
    err_d      = err_q;
    mic_ok_d   = mic_ok_q;
    mic_fail_d = mic_fail_q;
    wdog_d     = wdog_q;
    starve_d   = starve_q;

    tx_wins     = txReq && (!rxReq || (starve_q == STARVE_LIM));
    start       = (state_q == S_IDLE) && ccmpIsIdle && (txReq || rxReq);
    owner_err   = (tx_gnt_q && tcTxErrorP) || (rx_gnt_q && rxError_p);
    owner_drop  = (tx_gnt_q && !txReq) || (rx_gnt_q && !rxReq);
    wdog_expire = (state_q == S_RUN) && (wdog_q == WDOG_LIM) && !activity_p;
    drain_done  = (state_q == S_DRAIN) && ccmpIsIdle;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_INIT;
          tx_gnt_d = tx_wins;
          rx_gnt_d = !tx_wins;
          err_d    = 1'b0;
          wdog_d   = '0;
        end
      end
      S_INIT: state_d = S_RUN;
      S_RUN: begin
        if (activity_p) begin
          wdog_d = '0;
        end else if (!wdog_expire) begin
          wdog_d = wdog_q + WDOG_W'(1);
        end
        // Errors and aborts outrank a simultaneous micValid_p.
        err_d = owner_err || owner_drop || wdog_expire;
        if (owner_err || owner_drop || wdog_expire || micValid_p) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (ccmpIsIdle) begin
          state_d  = S_IDLE;
          tx_gnt_d = 1'b0;
          rx_gnt_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (!txReq || (start && tx_wins)) begin
      starve_d = '0;
    end else if (start && (starve_q != STARVE_LIM)) begin
      starve_d = starve_q + STARVE_W'(1);
    end

    if (start && !tx_wins) begin
      mic_ok_d   = 1'b0;
      mic_fail_d = 1'b0;
    end else if (rx_gnt_q) begin
      if (micPassed_p) mic_ok_d = 1'b1;
      if (micFailed_p) mic_fail_d = 1'b1;
    end
  end

  always_ff @(posedge macCoreClk) begin
    if (macCoreSRst) begin
      state_q    <= S_IDLE;
      tx_gnt_q   <= 1'b0;
      rx_gnt_q   <= 1'b0;
      err_q      <= 1'b0;
      mic_ok_q   <= 1'b0;
      mic_fail_q <= 1'b0;
      wdog_q     <= '0;
      starve_q   <= '0;
    end else begin
      state_q    <= state_d;
      tx_gnt_q   <= tx_gnt_d;
      rx_gnt_q   <= rx_gnt_d;
      err_q      <= err_d;
      mic_ok_q   <= mic_ok_d;
      mic_fail_q <= mic_fail_d;
      wdog_q     <= wdog_d;
      starve_q   <= starve_d;
    end
  end

  assign txGnt       = tx_gnt_q;
  assign rxGnt       = rx_gnt_q;
  assign schedCS     = state_q;
  assign initCCMP_p  = (state_q == S_INIT);
  assign rxMicOk     = mic_ok_q;
  assign rxMicFail   = mic_fail_q;
  // Pulses are masked while reset is asserted so a mid-session reset never
  // reports a completion.
  assign wdogAbort_p = wdog_expire && !macCoreSRst;
  assign txDone_p    = drain_done && tx_gnt_q && !macCoreSRst;
  assign rxDone_p    = drain_done && rx_gnt_q && !macCoreSRst;
  assign doneErr     = (txDone_p || rxDone_p) && err_q;

endmodule

// File: tb/tb_ccmp_sched.sv
// Randomized session-level bench for ccmp_sched with a scoreboard of
// expected completions and a behavioural arbitration/MIC model.
module tb_ccmp_sched;
  localparam int WDOG_MAX   = 8;
  localparam int STARVE_MAX = 3;

  logic       clk = 1'b0;
  logic       macCoreSRst, txReq, rxReq, ccmpIsIdle, activity_p;
  logic       micValid_p, micPassed_p, micFailed_p, rxError_p, tcTxErrorP;
  logic       txGnt, rxGnt, initCCMP_p, txDone_p, rxDone_p, doneErr;
  logic       rxMicOk, rxMicFail, wdogAbort_p;
  logic [1:0] schedCS;

  int         total = 0;
  int         bad = 0;
  logic [3:0] exp_q[$];
  int         m_starve;
  logic       m_ok, m_fail;
  logic       owner;

  ccmp_sched #(.WDOG_W(10), .WDOG_MAX(WDOG_MAX), .STARVE_MAX(STARVE_MAX)) dut (
    .macCoreClk(clk), .macCoreSRst(macCoreSRst), .txReq(txReq), .rxReq(rxReq),
    .ccmpIsIdle(ccmpIsIdle), .activity_p(activity_p), .micValid_p(micValid_p),
    .micPassed_p(micPassed_p), .micFailed_p(micFailed_p), .rxError_p(rxError_p),
    .tcTxErrorP(tcTxErrorP), .txGnt(txGnt), .rxGnt(rxGnt), .initCCMP_p(initCCMP_p),
    .txDone_p(txDone_p), .rxDone_p(rxDone_p), .doneErr(doneErr), .rxMicOk(rxMicOk),
    .rxMicFail(rxMicFail), .wdogAbort_p(wdogAbort_p), .schedCS(schedCS)
  );

  // Clock and time limit
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL timeout: run did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic clear_pulses();
    activity_p  = 1'b0;
    micValid_p  = 1'b0;
    micPassed_p = 1'b0;
    micFailed_p = 1'b0;
    rxError_p   = 1'b0;
    tcTxErrorP  = 1'b0;
  endtask

  // Monitor: pops one expected completion per done pulse
  always @(negedge clk) begin
    logic [3:0] got, want;
    chk("gnt_onehot", (txGnt && rxGnt) || (schedCS == 2'd0 && (txGnt || rxGnt)) ||
        (txDone_p && rxDone_p), 0);
    if (txDone_p || rxDone_p) begin
      chk("done_was_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        got  = {txDone_p, doneErr, rxMicOk, rxMicFail};
        want = exp_q.pop_front();
        chk("done_pkt{tx,err,ok,fail}", got, want);
      end
    end
  end

  // Driver: called inside an IDLE cycle before its closing edge; returns at
  // the negedge of the first RUN cycle.
  task automatic start_session(input logic tx, input logic rx, input int hold,
                               output logic owner_tx);
    txReq = tx;
    rxReq = rx;
    if (hold > 0) begin
      ccmpIsIdle = 1'b0;
      for (int i = 0; i < hold; i++) begin
        tick();
        mid();
        chk("held_off_cs", schedCS, 0);
        chk("held_off_gnt", {txGnt, rxGnt}, 0);
      end
    end
    ccmpIsIdle = 1'b1;
    owner_tx = tx && (!rx || m_starve == STARVE_MAX);
    if (!tx || owner_tx) m_starve = 0;
    else if (m_starve < STARVE_MAX) m_starve++;
    if (!owner_tx) begin
      m_ok   = 1'b0;
      m_fail = 1'b0;
    end
    tick();
    ccmpIsIdle = 1'b0;
    mid();
    chk("init_cs", schedCS, 1);
    chk("init_pulse", initCCMP_p, 1);
    chk("init_gnt", {txGnt, rxGnt}, owner_tx ? 2'b10 : 2'b01);
    tick();
    mid();
    chk("run_cs", schedCS, 2);
    chk("run_init_low", initCCMP_p, 0);
  endtask

  task automatic drain_tail();
    int w;
    tick();
    clear_pulses();
    mid();
    chk("drain_cs", schedCS, 3);
    w = $urandom_range(0, 2);
    for (int i = 0; i < w; i++) begin
      tick();
      mid();
      chk("drain_wait_cs", schedCS, 3);
    end
    tick();
    ccmpIsIdle = 1'b1;
    mid();
    chk("done_cycle_cs", schedCS, 3);
    tick();
    mid();
    chk("gap_cs", schedCS, 0);
    chk("gap_gnt", {txGnt, rxGnt}, 0);
  endtask

  // kinds: 0 mic pass, 1 mic fail, 2 owner error, 3 non-owner error then mic,
  // 4 owner request drop, 5 watchdog expiry, 6 activity at expiry then mic
  task automatic end_session(input int kind, input logic owner_tx);
    logic err;
    int   d;
    err = 1'b0;
    if (kind == 5 || kind == 6) begin
      for (int k = 1; k < WDOG_MAX; k++) begin
        tick();
        mid();
        chk("wdog_quiet", {schedCS, wdogAbort_p}, {2'd2, 1'b0});
      end
      tick();
      if (kind == 6) activity_p = 1'b1;
      mid();
      chk("wdog_abort", wdogAbort_p, (kind == 5) ? 1 : 0);
      if (kind == 6) begin
        tick();
        activity_p = 1'b0;
        micValid_p = 1'b1;
        mid();
        chk("wdog_survived_cs", schedCS, 2);
      end else begin
        err = 1'b1;
      end
      exp_q.push_back({owner_tx, err, m_ok, m_fail});
      drain_tail();
    end else begin
      d = $urandom_range(0, 3);
      for (int i = 0; i < d; i++) begin
        tick();
        activity_p = 1'($urandom_range(0, 1));
        mid();
        chk("run_busy_cs", schedCS, 2);
      end
      if (kind == 3) begin
        tick();
        clear_pulses();
        if (owner_tx) begin
          rxError_p   = 1'b1;
          micPassed_p = 1'b1;
        end else begin
          tcTxErrorP = 1'b1;
        end
        mid();
        tick();
        clear_pulses();
        mid();
        chk("nonowner_err_ignored", schedCS, 2);
      end
      tick();
      clear_pulses();
      case (kind)
        0: begin
          micValid_p  = 1'b1;
          micPassed_p = 1'b1;
          if (!owner_tx) m_ok = 1'b1;
        end
        1: begin
          micValid_p  = 1'b1;
          micFailed_p = 1'b1;
          if (!owner_tx) m_fail = 1'b1;
        end
        2: begin
          if (owner_tx) tcTxErrorP = 1'b1;
          else rxError_p = 1'b1;
          micValid_p = 1'($urandom_range(0, 1));
          err = 1'b1;
        end
        3: micValid_p = 1'b1;
        default: begin
          if (owner_tx) txReq = 1'b0;
          else rxReq = 1'b0;
          err = 1'b1;
        end
      endcase
      exp_q.push_back({owner_tx, err, m_ok, m_fail});
      mid();
      drain_tail();
    end
  endtask

  initial begin
    logic tx, rx;
    macCoreSRst = 1'b1;
    txReq = 1'b0;
    rxReq = 1'b0;
    ccmpIsIdle = 1'b1;
    clear_pulses();
    m_starve = 0;
    m_ok = 1'b0;
    m_fail = 1'b0;
    repeat (3) tick();
    mid();
    chk("reset_cs", schedCS, 0);
    chk("reset_outs", {txGnt, rxGnt, initCCMP_p, txDone_p, rxDone_p, doneErr,
                       rxMicOk, rxMicFail, wdogAbort_p}, 0);
    macCoreSRst = 1'b0;

    // RX alone, MIC pass
    start_session(1'b0, 1'b1, 0, owner);
    end_session(0, owner);

    // Both requests held: three RX grants, then TX is forced
    for (int i = 0; i < 5; i++) begin
      start_session(1'b1, 1'b1, 0, owner);
      chk("starve_order_tx", owner, (i == 3) ? 1 : 0);
      end_session($urandom_range(0, 4), owner);
    end

    // Engine busy in IDLE holds the request off
    start_session(1'b0, 1'b1, 3, owner);
    end_session(2, owner);

    // TX session: RX error and MIC ignored; then TX error
    start_session(1'b1, 1'b0, 0, owner);
    end_session(3, owner);
    start_session(1'b1, 1'b0, 0, owner);
    end_session(2, owner);

    // Watchdog expiry and activity on the expiry cycle
    start_session(1'b1, 1'b0, 0, owner);
    end_session(5, owner);
    start_session(1'b0, 1'b1, 0, owner);
    end_session(6, owner);

    // Reset mid-session clears sticky MIC status and regrants after release
    start_session(1'b0, 1'b1, 0, owner);
    end_session(0, owner);
    start_session(1'b1, 1'b0, 0, owner);
    macCoreSRst = 1'b1;
    tick();
    macCoreSRst = 1'b0;
    ccmpIsIdle = 1'b1;
    m_starve = 0;
    m_ok = 1'b0;
    m_fail = 1'b0;
    mid();
    chk("midrst_cs", schedCS, 0);
    chk("midrst_outs", {txGnt, rxGnt, initCCMP_p, txDone_p, rxDone_p, doneErr,
                        rxMicOk, rxMicFail, wdogAbort_p}, 0);
    tick();
    ccmpIsIdle = 1'b0;
    mid();
    chk("regrant", {txGnt, rxGnt, initCCMP_p, schedCS}, {1'b1, 1'b0, 1'b1, 2'd1});
    tick();
    mid();
    chk("regrant_run_cs", schedCS, 2);
    end_session(0, 1'b1);

    // Random sessions
    for (int i = 0; i < 40; i++) begin
      tx = 1'($urandom_range(0, 1));
      rx = 1'($urandom_range(0, 1));
      if (!tx && !rx) rx = 1'b1;
      start_session(tx, rx, ($urandom_range(0, 3) == 0) ? 2 : 0, owner);
      end_session($urandom_range(0, 6), owner);
    end

    repeat (3) tick();
    mid();
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
